// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_if
// Brief    : Start/Busy/Done operand and result bundle for the sequential ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] ALUResult;
  logic [WIDTH-1:0] ALUResultHi;
  logic             Zero;
  logic             Overflow;
  logic             DivByZero;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, ALUControl, A, B,
    input  ALUResult, ALUResultHi, Zero, Overflow, DivByZero, Busy, Done
  );

  modport slave (
    input  Start, ALUControl, A, B,
    output ALUResult, ALUResultHi, Zero, Overflow, DivByZero, Busy, Done
  );
endinterface
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Brief    : Registered ALU; single-cycle logic/arith ops plus multi-cycle
//            shift-add MUL and restoring DIVU behind a start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  seq_alu_if.slave    bus
);

  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_run  = 1'b1;

  localparam logic [3:0] c_op_and  = 4'b0000;
  localparam logic [3:0] c_op_or   = 4'b0001;
  localparam logic [3:0] c_op_add  = 4'b0010;
  localparam logic [3:0] c_op_sub  = 4'b0110;
  localparam logic [3:0] c_op_slt  = 4'b0111;
  localparam logic [3:0] c_op_nor  = 4'b1100;
  localparam logic [3:0] c_op_mul  = 4'b1000;
  localparam logic [3:0] c_op_divu = 4'b1001;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic [WIDTH-1:0] r_opd;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_zero;
  logic             r_ovf;
  logic             r_dbz;
  logic             r_done;

  logic [WIDTH-1:0] w_b_neg;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_res_hi;
  logic             w_ovf;
  logic             w_dbz;
  logic             w_multi;

  always_comb begin
    w_b_neg  = ~bus.B + WIDTH'(1);
    w_res    = '0;
    w_res_hi = '0;
    w_ovf    = 1'b0;
    w_dbz    = 1'b0;
    w_multi  = 1'b0;
    case (bus.ALUControl)
      c_op_and: w_res = bus.A & bus.B;
      c_op_or:  w_res = bus.A | bus.B;
      c_op_add: begin
        w_res = bus.A + bus.B;
        w_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (w_res[WIDTH-1] != bus.A[WIDTH-1]);
      end
      c_op_sub: begin
        w_res = bus.A + w_b_neg;
        w_ovf = (bus.A[WIDTH-1] == w_b_neg[WIDTH-1]) && (w_res[WIDTH-1] != bus.A[WIDTH-1]);
      end
      c_op_slt: w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      c_op_nor: w_res = ~(bus.A | bus.B);
      c_op_mul: w_multi = 1'b1;
      c_op_divu: begin
        if (bus.B == '0) begin
          w_res    = '1;
          w_res_hi = bus.A;
          w_dbz    = 1'b1;
        end else begin
          w_multi = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // One iteration of either algorithm; r_hi:r_lo is the shared working pair.
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_diff;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;

  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
    w_div_shift = {r_hi, r_lo[WIDTH-1]};
    w_div_diff  = w_div_shift - {1'b0, r_opd};
    if (r_is_div) begin
      w_step_hi = w_div_diff[WIDTH] ? w_div_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
      w_step_lo = {r_lo[WIDTH-2:0], ~w_div_diff[WIDTH]};
    end else begin
      w_step_hi = w_mul_sum[WIDTH:1];
      w_step_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_idle;
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_opd       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_dbz       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_idle: begin
          if (bus.Start) begin
            if (w_multi) begin
              r_state  <= c_run;
              r_cnt    <= CNT_W'(WIDTH);
              r_is_div <= (bus.ALUControl == c_op_divu);
              r_opd    <= (bus.ALUControl == c_op_divu) ? bus.B : bus.A;
              r_lo     <= (bus.ALUControl == c_op_divu) ? bus.A : bus.B;
              r_hi     <= '0;
            end else begin
              r_result    <= w_res;
              r_result_hi <= w_res_hi;
              r_zero      <= (w_res == '0);
              r_ovf       <= w_ovf;
              r_dbz       <= w_dbz;
              r_done      <= 1'b1;
            end
          end
        end
        c_run: begin
          r_hi  <= w_step_hi;
          r_lo  <= w_step_lo;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state     <= c_idle;
            r_result    <= w_step_lo;
            r_result_hi <= w_step_hi;
            r_zero      <= (w_step_lo == '0);
            r_ovf       <= 1'b0;
            r_dbz       <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign bus.ALUResult   = r_result;
  assign bus.ALUResultHi = r_result_hi;
  assign bus.Zero        = r_zero;
  assign bus.Overflow    = r_ovf;
  assign bus.DivByZero   = r_dbz;
  assign bus.Busy        = (r_state == c_run);
  assign bus.Done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu
// Brief    : Directed plus random stimulus for seq_alu against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  seq_alu_if #(.WIDTH(32)) bus ();

  seq_alu #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // Expected results straight from the operation definitions, using wide arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] lo, output logic [31:0] hi,
                       output logic ovf, output logic dbz, output int lat);
    longint      s;
    logic [63:0] p;
    logic [31:0] bn;
    lo = 0; hi = 0; ovf = 0; dbz = 0; lat = 1;
    case (op)
      4'b0000: lo = a & b;
      4'b0001: lo = a | b;
      4'b0010: begin
        s   = longint'($signed(a)) + longint'($signed(b));
        lo  = a + b;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        bn  = 32'd0 - b;
        s   = longint'($signed(a)) + longint'($signed(bn));
        lo  = a - b;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: lo = ~(a | b);
      4'b1000: begin
        p  = {32'd0, a} * {32'd0, b};
        lo = p[31:0];
        hi = p[63:32];
        lat = 33;
      end
      4'b1001: begin
        if (b == 0) begin
          lo = 32'hFFFF_FFFF; hi = a; dbz = 1;
        end else begin
          lo = a / b; hi = a % b; lat = 33;
        end
      end
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke, input string tag);
    logic [31:0] elo, ehi;
    logic        eovf, edbz;
    int          elat, lat, busy_cycles;
    model(op, a, b, elo, ehi, eovf, edbz, elat);
    @(negedge clk);
    bus.Start = 1'b1; bus.ALUControl = op; bus.A = a; bus.B = b;
    lat = 0; busy_cycles = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (bus.Done !== 1'b1) begin
        if (bus.Busy === 1'b1) busy_cycles++;
        if (poke) begin
          bus.Start = 1'($urandom); bus.A = $urandom; bus.B = $urandom;
          bus.ALUControl = 4'($urandom);
        end else begin
          bus.Start = 1'b0;
        end
      end
    end while (bus.Done !== 1'b1 && lat < 100);
    bus.Start = 1'b0;
    check(tag, "latency", 64'(lat), 64'(elat));
    check(tag, "busy_cycles", 64'(busy_cycles), 64'(elat - 1));
    check(tag, "busy_at_done", 64'(bus.Busy), 64'(0));
    check(tag, "lo", 64'(bus.ALUResult), 64'(elo));
    check(tag, "hi", 64'(bus.ALUResultHi), 64'(ehi));
    check(tag, "zero", 64'(bus.Zero), 64'(elo == 0));
    check(tag, "ovf", 64'(bus.Overflow), 64'(eovf));
    check(tag, "dbz", 64'(bus.DivByZero), 64'(edbz));
  endtask

  initial begin
    logic [3:0] ops [10];
    logic [3:0] op;
    logic [31:0] ra, rb;
    int done_seen;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000, 4'b1001, 4'b0011, 4'b1111};

    bus.Start = 1'b0; bus.ALUControl = 4'd0; bus.A = 32'd0; bus.B = 32'd0;
    #23;
    check("reset", "lo", 64'(bus.ALUResult), 64'(0));
    check("reset", "hi", 64'(bus.ALUResultHi), 64'(0));
    check("reset", "flags", 64'({bus.Zero, bus.Overflow, bus.DivByZero}), 64'(0));
    check("reset", "busy_done", 64'({bus.Busy, bus.Done}), 64'(0));
    @(negedge clk); rst_n = 1'b1;

    run_op(4'b0010, 32'd4, 32'd2, 0, "add_4_2");
    @(posedge clk); #1;
    check("hold", "done_pulse", 64'(bus.Done), 64'(0));
    check("hold", "lo", 64'(bus.ALUResult), 64'(6));
    run_op(4'b0110, 32'd4, 32'd4, 0, "sub_zero");
    run_op(4'b0010, 32'h7FFF_FFFF, 32'd1, 0, "add_ovf");
    run_op(4'b0110, 32'h8000_0000, 32'd1, 0, "sub_ovf");
    run_op(4'b1000, 32'hFFFF_FFFF, 32'd2, 0, "mul_big");
    run_op(4'b1001, 32'd100, 32'd7, 1, "divu_100_7");
    run_op(4'b1001, 32'd9, 32'd0, 0, "divu_by0");
    run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 0, "slt_neg");
    run_op(4'b0111, 32'd5, 32'hFFFF_FFF0, 0, "slt_pos");
    run_op(4'b1100, 32'h0F0F_0000, 32'h0000_00FF, 0, "nor");
    run_op(4'b0011, 32'd12, 32'd34, 0, "undef");
    run_op(4'b1000, 32'd0, 32'hDEAD_BEEF, 1, "mul_zero");
    run_op(4'b1001, 32'd3, 32'd10, 0, "divu_small");

    for (int i = 0; i < 30; i++) begin
      op = ops[$urandom_range(0, 9)];
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      run_op(op, ra, rb, 1'($urandom), "random");
    end

    run_op(4'b0010, 32'd5, 32'd5, 0, "pre_reset");
    @(negedge clk);
    bus.Start = 1'b1; bus.ALUControl = 4'b1000; bus.A = 32'd3; bus.B = 32'd5;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst", "lo", 64'(bus.ALUResult), 64'(0));
    check("async_rst", "busy_done", 64'({bus.Busy, bus.Done}), 64'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.Done === 1'b1) done_seen++;
    end
    check("async_rst", "no_done", 64'(done_seen), 64'(0));
    run_op(4'b0010, 32'd1, 32'd1, 0, "add_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
